// File: rtl/mem_elastic_reg_if.sv
// MEM->WB handshake bundle: upstream push side and downstream pop side.
// master drives the in_* side and out_ready; slave is the buffer.
interface mem_elastic_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int GPR_W  = 5,
  parameter int CTRL_W = 2,
  parameter int EXP_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic              in_en;
  logic              in_br_flag;
  logic [CTRL_W-1:0] in_ctrl_op;
  logic [GPR_W-1:0]  in_dst_addr;
  logic              in_gpr_we_;
  logic [EXP_W-1:0]  in_exp_code;
  logic              in_miss_align;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic              out_en;
  logic              out_br_flag;
  logic [CTRL_W-1:0] out_ctrl_op;
  logic [GPR_W-1:0]  out_dst_addr;
  logic              out_gpr_we_;
  logic [EXP_W-1:0]  out_exp_code;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_pc, in_en, in_br_flag,
    output in_ctrl_op, in_dst_addr, in_gpr_we_,
    output in_exp_code, in_miss_align, in_data,
    output out_ready,
    input  in_ready, out_valid, out_pc, out_en,
    input  out_br_flag, out_ctrl_op, out_dst_addr,
    input  out_gpr_we_, out_exp_code, out_data
  );

  modport slave (
    input  in_valid, in_pc, in_en, in_br_flag,
    input  in_ctrl_op, in_dst_addr, in_gpr_we_,
    input  in_exp_code, in_miss_align, in_data,
    input  out_ready,
    output in_ready, out_valid, out_pc, out_en,
    output out_br_flag, out_ctrl_op, out_dst_addr,
    output out_gpr_we_, out_exp_code, out_data
  );
endinterface

// File: rtl/mem_elastic_reg.sv
// MEM->WB elastic pipeline register: DEPTH-entry circular buffer
// with misalign-to-exception rewrite and exception push counter.
module mem_elastic_reg #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 30,
  parameter int GPR_W          = 5,
  parameter int CTRL_W         = 2,
  parameter int EXP_W          = 3,
  parameter int DEPTH          = 2,
  parameter int CTRL_NOP       = 0,
  parameter int EXP_NONE       = 0,
  parameter int EXP_MISS_ALIGN = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_elastic_reg_if.slave bus,
  output logic [OCC_W-1:0] occupancy,
  output logic [15:0]      exp_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              en;
    logic              br_flag;
    logic [CTRL_W-1:0] ctrl_op;
    logic [GPR_W-1:0]  dst_addr;
    logic              gpr_we_;
    logic [EXP_W-1:0]  exp_code;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             mem [DEPTH];
  ent_t             in_ent;
  ent_t             head;
  ent_t             idle;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             has_exp;

  assign bus.in_ready  = occupancy < OCC_W'(DEPTH);
  assign bus.out_valid = occupancy != '0;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // An earlier-stage exception outranks a misalignment.
  always_comb begin
    in_ent.pc       = bus.in_pc;
    in_ent.en       = bus.in_en;
    in_ent.br_flag  = bus.in_br_flag;
    in_ent.ctrl_op  = bus.in_ctrl_op;
    in_ent.dst_addr = bus.in_dst_addr;
    in_ent.gpr_we_  = bus.in_gpr_we_;
    in_ent.exp_code = bus.in_exp_code;
    in_ent.data     = bus.in_data;
    unique case (1'b1)
      (bus.in_exp_code == EXP_W'(EXP_NONE)
       && bus.in_miss_align): begin
        in_ent.ctrl_op  = CTRL_W'(CTRL_NOP);
        in_ent.dst_addr = '0;
        in_ent.gpr_we_  = 1'b1;
        in_ent.exp_code = EXP_W'(EXP_MISS_ALIGN);
        in_ent.data     = '0;
      end
      default: ;
    endcase
  end

  assign has_exp = in_ent.exp_code != EXP_W'(EXP_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_cnt   <= '0;
    end else if (flush) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        occupancy <= occupancy + OCC_W'(1);
      else if (pop && !push)
        occupancy <= occupancy - OCC_W'(1);
      if (push && has_exp && exp_cnt != 16'hFFFF)
        exp_cnt <= exp_cnt + 16'd1;
    end
  end

  // Payload needs no reset: out_* are masked to idle while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_ent;
  end

  always_comb begin
    idle          = '0;
    idle.ctrl_op  = CTRL_W'(CTRL_NOP);
    idle.gpr_we_  = 1'b1;
    idle.exp_code = EXP_W'(EXP_NONE);
    head = bus.out_valid ? mem[rd_ptr] : idle;
  end

  assign bus.out_pc       = head.pc;
  assign bus.out_en       = head.en;
  assign bus.out_br_flag  = head.br_flag;
  assign bus.out_ctrl_op  = head.ctrl_op;
  assign bus.out_dst_addr = head.dst_addr;
  assign bus.out_gpr_we_  = head.gpr_we_;
  assign bus.out_exp_code = head.exp_code;
  assign bus.out_data     = head.data;

endmodule

// File: tb/tb_mem_elastic_reg.sv
// Bench for mem_elastic_reg: directed steps then random traffic
// against a queue-based reference of the buffer contents.
module tb_mem_elastic_reg;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  xc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;
  logic [15:0] exp_cnt;

  mem_elastic_reg_if bus ();

  mem_elastic_reg #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus.slave),
    .occupancy(occupancy),
    .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   cnt = 0;
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag,
                     input logic [74:0] obs,
                     input logic [74:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic ent_t rewrite(input ent_t e,
                                   input logic ma);
    ent_t r = e;
    if (e.xc == 3'd0 && ma) begin
      r.ctrl = 2'd0;
      r.dst  = 5'd0;
      r.we_  = 1'b1;
      r.xc   = 3'd4;
      r.data = 32'd0;
    end
    return r;
  endfunction

  function automatic ent_t mk(input logic [29:0] pc,
                              input logic [1:0] ctrl,
                              input logic [4:0] dst,
                              input logic we_,
                              input logic [2:0] xc,
                              input logic [31:0] data);
    ent_t e;
    e.pc = pc; e.en = 1'b1; e.br = pc[0];
    e.ctrl = ctrl; e.dst = dst; e.we_ = we_;
    e.xc = xc; e.data = data;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    ent_t idle;
    ent_t expd;
    ent_t obs;
    idle = '0;
    idle.we_ = 1'b1;
    expd = (q.size() != 0) ? q[0] : idle;
    obs = {bus.out_pc, bus.out_en, bus.out_br_flag,
           bus.out_ctrl_op, bus.out_dst_addr,
           bus.out_gpr_we_, bus.out_exp_code, bus.out_data};
    chk({tag, ".out_valid"}, 75'(bus.out_valid),
        75'(q.size() != 0));
    chk({tag, ".in_ready"}, 75'(bus.in_ready),
        75'(q.size() < DEPTH));
    chk({tag, ".occupancy"}, 75'(occupancy), 75'(q.size()));
    chk({tag, ".exp_cnt"}, 75'(exp_cnt), 75'(cnt));
    chk({tag, ".fields"}, obs, expd);
  endtask

  task automatic drive(input string tag, input ent_t e,
                       input logic v, input logic ma,
                       input logic ordy, input logic fl,
                       output logic acc);
    ent_t r;
    bus.in_valid = v;
    bus.in_pc = e.pc;
    bus.in_en = e.en;
    bus.in_br_flag = e.br;
    bus.in_ctrl_op = e.ctrl;
    bus.in_dst_addr = e.dst;
    bus.in_gpr_we_ = e.we_;
    bus.in_exp_code = e.xc;
    bus.in_miss_align = ma;
    bus.in_data = e.data;
    bus.out_ready = ordy;
    flush = fl;
    @(posedge clk);
    acc = v && (q.size() < DEPTH);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
        r = rewrite(e, ma);
        q.push_back(r);
        if (r.xc != 3'd0 && cnt < 65535) cnt++;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    ent_t e;
    ent_t nul;
    logic acc;
    logic pend;
    logic pma;
    nul = '0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_en = 1'b0;
    bus.in_br_flag = 1'b0;
    bus.in_ctrl_op = '0;
    bus.in_dst_addr = '0;
    bus.in_gpr_we_ = 1'b1;
    bus.in_exp_code = '0;
    bus.in_miss_align = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    #2;
    check_outputs("reset");
    chk("reset.gpr_we_", 75'(bus.out_gpr_we_), 75'(1));
    chk("reset.exp_code", 75'(bus.out_exp_code), 75'(0));
    #6 rst = 1'b1;
    @(negedge clk);

    e = mk(30'h10, 2'd0, 5'd3, 1'b0, 3'd0, 32'hDEADBEEF);
    drive("push1", e, 1, 0, 1, 0, acc);
    chk("push1.data", 75'(bus.out_data), 75'(32'hDEADBEEF));
    chk("push1.occ", 75'(occupancy), 75'(1));
    drive("pop1", nul, 0, 0, 1, 0, acc);
    chk("pop1.occ", 75'(occupancy), 75'(0));

    for (int k = 0; k < 3; k++) begin
      e = mk(30'h20 + 30'(k), 2'd1, 5'(k + 1), 1'b0,
             3'd0, 32'h100 + 32'(k));
      drive("fill", e, 1, 0, 0, 0, acc);
    end
    chk("full.in_ready", 75'(bus.in_ready), 75'(0));
    e = mk(30'h23, 2'd1, 5'd4, 1'b0, 3'd0, 32'h103);
    drive("held", e, 1, 0, 0, 0, acc);
    chk("held.acc", 75'(acc), 75'(0));
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++)
      drive("drain", e, 1, 0, 1, 0, acc);
    chk("held.accepted", 75'(acc), 75'(1));
    for (int k = 0; k < 4; k++)
      drive("empty", nul, 0, 0, 1, 0, acc);

    e = mk(30'h31, 2'd1, 5'd7, 1'b0, 3'd0, 32'h55);
    drive("misalign", e, 1, 1, 0, 0, acc);
    chk("misalign.exp", 75'(bus.out_exp_code), 75'(4));
    chk("misalign.cnt", 75'(exp_cnt), 75'(1));
    drive("misalign_pop", nul, 0, 0, 1, 0, acc);
    e = mk(30'h40, 2'd2, 5'd9, 1'b0, 3'd2, 32'h77);
    drive("early_exp", e, 1, 1, 0, 0, acc);
    chk("early_exp.exp", 75'(bus.out_exp_code), 75'(2));
    chk("early_exp.data", 75'(bus.out_data), 75'(32'h77));
    drive("early_pop", nul, 0, 0, 1, 0, acc);

    drive("pre_flush", mk(30'h50, 0, 1, 0, 0, 1),
          1, 0, 0, 0, acc);
    drive("pre_flush", mk(30'h51, 0, 2, 0, 0, 2),
          1, 0, 0, 0, acc);
    drive("flush", mk(30'h52, 0, 3, 0, 5, 3),
          1, 0, 1, 1, acc);
    chk("flush.occ", 75'(occupancy), 75'(0));
    drive("post_flush", mk(30'h53, 0, 4, 0, 0, 4),
          1, 0, 0, 0, acc);
    drive("post_pop", nul, 0, 0, 1, 0, acc);

    pend = 1'b0;
    pma = 1'b0;
    e = nul;
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = pend || ($urandom_range(9) < 7);
      if (!pend) begin
        e = ent_t'({$urandom, $urandom, $urandom});
        if ($urandom_range(3) != 0) e.xc = 3'd0;
        pma = ($urandom_range(4) == 0);
      end
      if (i == 300) begin
        rst = 1'b0;
        #1;
        q.delete();
        cnt = 0;
        check_outputs("midreset");
        #1 rst = 1'b1;
        pend = 1'b0;
      end
      drive("rand", e, v, pma, 1'($urandom_range(1)),
            ($urandom_range(39) == 0), acc);
      pend = v && !acc;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
